// File: rtl/base_window_packer.sv
// Sliding-window packer: turns a serial 2-bit base stream into packed BASES-wide windows,
// each tagged with the sequence position of its oldest base.
module base_window_packer #(
  parameter int BASES = 4,
  parameter int POS_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_base,
  input  logic                 in_n,
  input  logic                 in_sop,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*BASES-1:0]   out_window,
  output logic [POS_W-1:0]     out_pos
);

  localparam int WIN_W  = 2 * BASES;
  localparam int FILL_W = $clog2(BASES + 1);

  // Fill count saturates at a full window; once full every new base slides it.
  function automatic logic [FILL_W-1:0] sat_fill(input logic [FILL_W-1:0] f);
    if (f >= FILL_W'(BASES)) begin
      return FILL_W'(BASES);
    end
    return f + FILL_W'(1);
  endfunction

  function automatic logic [WIN_W-1:0] shift_in(input logic [WIN_W-1:0] w,
                                                input logic [1:0]       b);
    return {w[WIN_W-3:0], b};
  endfunction

  logic [WIN_W-1:0]  window_p0;
  logic [FILL_W-1:0] fill_p0;
  logic [POS_W-1:0]  pos_p0;

  logic [WIN_W-1:0]  win_p1;
  logic [POS_W-1:0]  pos_p1;
  logic              vld_p1;

  logic              accept;
  logic              emit;
  logic [WIN_W-1:0]  win_nxt;
  logic [FILL_W-1:0] fill_nxt;
  logic [POS_W-1:0]  idx_nxt;
  logic [POS_W-1:0]  start_pos;

  assign in_ready   = !vld_p1 || out_ready;
  assign accept     = in_valid && in_ready;
  assign out_valid  = vld_p1;
  assign out_window = win_p1;
  assign out_pos    = pos_p1;

  always_comb begin
    win_nxt  = window_p0;
    fill_nxt = fill_p0;
    idx_nxt  = in_sop ? '0 : pos_p0 + POS_W'(1);
    if (in_n) begin
      // An ambiguous base poisons the window but still occupies a position.
      win_nxt  = '0;
      fill_nxt = '0;
    end else if (in_sop) begin
      win_nxt  = WIN_W'(in_base);
      fill_nxt = FILL_W'(1);
    end else begin
      win_nxt  = shift_in(window_p0, in_base);
      fill_nxt = sat_fill(fill_p0);
    end
    emit      = accept && (fill_nxt == FILL_W'(BASES));
    start_pos = idx_nxt - POS_W'(BASES - 1);
  end

  // Stage p0: window assembly and position tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      window_p0 <= '0;
      fill_p0   <= '0;
      pos_p0    <= '0;
    end else if (accept) begin
      window_p0 <= win_nxt;
      fill_p0   <= fill_nxt;
      pos_p0    <= idx_nxt;
    end
  end

  // Stage p1: single output register; a consume and an emit may share a cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      win_p1 <= '0;
      pos_p1 <= '0;
    end else if (emit) begin
      vld_p1 <= 1'b1;
      win_p1 <= win_nxt;
      pos_p1 <= start_pos;
    end else if (out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

endmodule

// File: tb/tb_base_window_packer.sv
// Bench for base_window_packer: queue-based reference model plus directed literal checks.
module tb_base_window_packer;
  localparam int BASES = 4;
  localparam int POS_W = 16;
  localparam int WIN_W = 2 * BASES;
  localparam int POS_M = 1 << POS_W;

  logic             clk = 1'b0;
  logic             rst, in_valid, in_ready, in_n, in_sop, out_valid, out_ready;
  logic [1:0]       in_base;
  logic [WIN_W-1:0] out_window;
  logic [POS_W-1:0] out_pos;

  always #5 clk = ~clk;

  base_window_packer #(.BASES(BASES), .POS_W(POS_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_base(in_base), .in_n(in_n), .in_sop(in_sop), .out_valid(out_valid),
    .out_ready(out_ready), .out_window(out_window), .out_pos(out_pos)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: the bases since the last restart, last index, expected output.
  int hist[$];
  int prev_idx  = 0;
  bit exp_valid = 1'b0;
  int exp_win   = 0;
  int exp_pos   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit v, input int b, input bit n, input bit s,
                      input bit o);
    bit rdy, acc, emit;
    int idx, w;
    rst = r; in_valid = v; in_base = b[1:0]; in_n = n; in_sop = s; out_ready = o;
    #1;
    rdy = !exp_valid || o;
    if (!r) chk("in_ready", in_ready, rdy);
    @(posedge clk);
    acc  = v && rdy;
    emit = 1'b0;
    idx  = 0;
    if (r) begin
      hist.delete();
      prev_idx = 0; exp_valid = 1'b0; exp_win = 0; exp_pos = 0;
    end else begin
      if (acc) begin
        idx = s ? 0 : (prev_idx + 1) % POS_M;
        prev_idx = idx;
        if (n) hist.delete();
        else begin
          if (s) hist.delete();
          hist.push_back(b & 3);
          if (hist.size() > BASES) void'(hist.pop_front());
          emit = (hist.size() == BASES);
        end
      end
      if (emit) begin
        w = 0;
        foreach (hist[i]) w = (w << 2) | hist[i];
        exp_valid = 1'b1;
        exp_win   = w;
        exp_pos   = (idx - (BASES - 1) + POS_M) % POS_M;
      end else if (o) begin
        exp_valid = 1'b0;
      end
    end
    @(negedge clk);
    chk("out_valid", out_valid, exp_valid);
    if (exp_valid || r) begin
      chk("out_window", out_window, exp_win);
      chk("out_pos", out_pos, exp_pos);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_base = 2'd0; in_n = 1'b0; in_sop = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_window", out_window, 0);
    chk("rst_pos", out_pos, 0);
    chk("rst_ready", in_ready, 1);

    // Basic fill A C G T
    step(0, 1, 0, 0, 1, 1); chk("fill1_valid", out_valid, 0);
    step(0, 1, 1, 0, 0, 1); chk("fill2_valid", out_valid, 0);
    step(0, 1, 2, 0, 0, 1); chk("fill3_valid", out_valid, 0);
    step(0, 1, 3, 0, 0, 1);
    chk("fill_valid", out_valid, 1);
    chk("fill_window", out_window, 8'h1B);
    chk("fill_pos", out_pos, 0);

    // Slide with A
    step(0, 1, 0, 0, 0, 1);
    chk("slide_valid", out_valid, 1);
    chk("slide_window", out_window, 8'h6C);
    chk("slide_pos", out_pos, 1);

    // Backpressure
    for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 0, 0);
    chk("bp_ready", in_ready, 0);
    chk("bp_window", out_window, 8'h6C);
    chk("bp_pos", out_pos, 1);
    step(0, 1, 1, 0, 0, 1);
    chk("bp_resume_window", out_window, 8'hB1);
    chk("bp_resume_pos", out_pos, 2);

    // N handling: A C G N T T G C
    step(0, 1, 0, 0, 1, 1);
    step(0, 1, 1, 0, 0, 1);
    step(0, 1, 2, 0, 0, 1);
    step(0, 1, 0, 1, 0, 1); chk("n_valid0", out_valid, 0);
    step(0, 1, 3, 0, 0, 1); chk("n_valid1", out_valid, 0);
    step(0, 1, 3, 0, 0, 1); chk("n_valid2", out_valid, 0);
    step(0, 1, 2, 0, 0, 1); chk("n_valid3", out_valid, 0);
    step(0, 1, 1, 0, 0, 1);
    chk("n_window", out_window, 8'hF9);
    chk("n_pos", out_pos, 4);

    // Mid-stream sop: six bases, then sop G A C T
    step(0, 1, 0, 0, 1, 1);
    for (int i = 0; i < 5; i++) step(0, 1, (i + 1) & 3, 0, 0, 1);
    step(0, 1, 2, 0, 1, 1); chk("sop_valid1", out_valid, 0);
    step(0, 1, 0, 0, 0, 1); chk("sop_valid2", out_valid, 0);
    step(0, 1, 1, 0, 0, 1); chk("sop_valid3", out_valid, 0);
    step(0, 1, 3, 0, 0, 1);
    chk("sop_window", out_window, 8'h87);
    chk("sop_pos", out_pos, 0);

    // Position wrap at full width
    step(0, 1, 0, 0, 1, 1);
    for (int k = 1; k < POS_M + 4; k++) begin
      step(0, 1, $urandom_range(0, 3), 0, 0, 1);
      if (k == POS_M + 2) chk("wrap_pos_ffff", out_pos, 16'hFFFF);
      if (k == POS_M + 3) chk("wrap_pos_0", out_pos, 0);
    end

    // Reset while holding a window
    step(0, 1, 2, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_ready", in_ready, 1);
    step(0, 1, 1, 0, 1, 1); chk("rst_refill1", out_valid, 0);
    step(0, 1, 2, 0, 0, 1); chk("rst_refill2", out_valid, 0);
    step(0, 1, 3, 0, 0, 1); chk("rst_refill3", out_valid, 0);
    step(0, 1, 0, 0, 0, 1);
    chk("rst_refill4", out_valid, 1);
    chk("rst_refill_window", out_window, 8'h6C);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3),
           $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
